// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM sample feeder: FSM state encoding and the
// FIFO fill level at which playback starts.
package pdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Playback starts once the FIFO is half full.
    function automatic int unsigned prime_threshold(input int unsigned depth_log2);
        return 32'd1 << (depth_log2 - 32'd1);
    endfunction

endpackage

// File: rtl/pdm_feed_if.sv
// Valid/ready sample stream into the PDM feeder; the source is the master.
interface pdm_feed_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pdm_feed_fifo.sv
// First-word-fall-through sample FIFO with an exact occupancy count and a
// synchronous flush that overrides any same-cycle push or pop.
module pdm_feed_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: the sample RAM has no reset; pointers and level alone define
    // which entries are meaningful, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/pdm_feed.sv
// PDM sample feeder: buffers a PCM stream and releases one sample every
// cfg_div+1 cycles, with priming, underrun detection and an idle level.
module pdm_feed
    import pdm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pdm_feed_if.slave            in_if,
    input  logic                 cfg_ena,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0]     cfg_idle,
    output logic [WIDTH-1:0]     out_val,
    output logic                 out_tick,
    output logic [DEPTH_LOG2:0]  stat_level,
    output logic                 stat_underrun,
    input  logic                 stat_clr
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] PRIME_LEVEL = LW'(prime_threshold(DEPTH_LOG2));

    state_t               state, state_nx;
    logic [DIV_WIDTH-1:0] div_cnt, div_nx;
    logic [WIDTH-1:0]     val_nx;
    logic                 tick_nx;
    logic                 pop, push, flush, underrun_evt;
    logic [WIDTH-1:0]     head;
    logic                 full, empty;

    assign in_if.in_ready = (state != ST_IDLE) && !full;
    assign push           = in_if.in_valid && in_if.in_ready && !flush;

    pdm_feed_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (in_if.in_data),
        .pop       (pop),
        .head      (head),
        .level     (stat_level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_nx     = state;
        div_nx       = div_cnt;
        val_nx       = out_val;
        tick_nx      = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        underrun_evt = 1'b0;

        case (state)
            ST_IDLE: begin
                val_nx = cfg_idle;
                div_nx = '0;
                if (cfg_ena) state_nx = ST_PRIME;
            end
            ST_PRIME: begin
                if (stat_level >= PRIME_LEVEL) begin
                    div_nx   = cfg_div;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (div_cnt == '0) begin
                    div_nx = cfg_div;
                    // An empty FIFO at the tick is an underrun even if a push
                    // lands in the same cycle: there is no read-through.
                    if (!empty) begin
                        pop     = 1'b1;
                        val_nx  = head;
                        tick_nx = 1'b1;
                    end else begin
                        underrun_evt = 1'b1;
                        state_nx     = ST_PRIME;
                    end
                end else begin
                    div_nx = div_cnt - DIV_WIDTH'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // Disable overrides everything decided above.
        if (!cfg_ena) begin
            state_nx     = ST_IDLE;
            div_nx       = '0;
            val_nx       = cfg_idle;
            tick_nx      = 1'b0;
            pop          = 1'b0;
            underrun_evt = 1'b0;
            flush        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt       <= '0;
            out_val       <= '0;
            out_tick      <= 1'b0;
            stat_underrun <= 1'b0;
        end else begin
            div_cnt  <= div_nx;
            out_val  <= val_nx;
            out_tick <= tick_nx;
            if (underrun_evt)  stat_underrun <= 1'b1;
            else if (stat_clr) stat_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_feed.sv
// Directed bench for pdm_feed: reset/idle, priming and playback, underrun,
// back-pressure, disable, cfg_div=0 and asynchronous reset.
module tb_pdm_feed;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int DIV_WIDTH  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_ena;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0]     cfg_idle;
    logic [WIDTH-1:0]     out_val;
    logic                 out_tick;
    logic [DEPTH_LOG2:0]  stat_level;
    logic                 stat_underrun;
    logic                 stat_clr;

    always #5 clk = ~clk;

    pdm_feed_if #(.WIDTH(WIDTH)) bus ();

    pdm_feed #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_if         (bus),
        .cfg_ena       (cfg_ena),
        .cfg_div       (cfg_div),
        .cfg_idle      (cfg_idle),
        .out_val       (out_val),
        .out_tick      (out_tick),
        .stat_level    (stat_level),
        .stat_underrun (stat_underrun),
        .stat_clr      (stat_clr)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         step;
        logic       tick;
        logic [7:0] val;
        logic [4:0] level;
        logic       underrun;
    } run_vec_t;

    run_vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_data  = base + 8'(i);
            bus.in_valid = 1'b1;
            if (i == 0) check("push_ready", 32'(bus.in_ready), 1);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            step();
            n++;
            if (out_tick) ok = 1'b1;
        end
    endtask

    initial begin
        int  idx, nticks, accepted, cyc;
        bit  ok;

        // Playback of 0x10..0x17 at cfg_div=3; step 1 is the RUN-entry edge.
        vecs[0]  = '{1,  1'b0, 8'h80, 5'd8, 1'b0};
        vecs[1]  = '{4,  1'b0, 8'h80, 5'd8, 1'b0};
        vecs[2]  = '{5,  1'b1, 8'h10, 5'd7, 1'b0};
        vecs[3]  = '{6,  1'b0, 8'h10, 5'd7, 1'b0};
        vecs[4]  = '{9,  1'b1, 8'h11, 5'd6, 1'b0};
        vecs[5]  = '{13, 1'b1, 8'h12, 5'd5, 1'b0};
        vecs[6]  = '{17, 1'b1, 8'h13, 5'd4, 1'b0};
        vecs[7]  = '{21, 1'b1, 8'h14, 5'd3, 1'b0};
        vecs[8]  = '{25, 1'b1, 8'h15, 5'd2, 1'b0};
        vecs[9]  = '{29, 1'b1, 8'h16, 5'd1, 1'b0};
        vecs[10] = '{32, 1'b0, 8'h16, 5'd1, 1'b0};
        vecs[11] = '{33, 1'b1, 8'h17, 5'd0, 1'b0};
        vecs[12] = '{36, 1'b0, 8'h17, 5'd0, 1'b0};
        vecs[13] = '{37, 1'b0, 8'h17, 5'd0, 1'b1};
        vecs[14] = '{41, 1'b0, 8'h17, 5'd0, 1'b1};

        rst          = 1'b1;
        cfg_ena      = 1'b0;
        cfg_div      = '0;
        cfg_idle     = 8'h80;
        stat_clr     = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;

        // Reset / idle
        #2;
        check("rst_out_val",  32'(out_val), 0);
        check("rst_out_tick", 32'(out_tick), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_level",    32'(stat_level), 0);
        check("rst_underrun", 32'(stat_underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_pre_edge_val", 32'(out_val), 0);
        @(negedge clk);
        check("idle_val",      32'(out_val), 32'h80);
        check("idle_in_ready", 32'(bus.in_ready), 0);
        check("idle_level",    32'(stat_level), 0);

        // Prime and run, then underrun
        cfg_div = 16'd3;
        cfg_ena = 1'b1;
        step();
        check("prime_in_ready", 32'(bus.in_ready), 1);
        check("prime_hold_val", 32'(out_val), 32'h80);
        push_seq(8'h10, 8);
        check("prime_level", 32'(stat_level), 8);
        idx    = 0;
        nticks = 0;
        for (int k = 1; k <= 41; k++) begin
            step();
            if (out_tick) nticks++;
            if (idx < 15 && k == vecs[idx].step) begin
                check($sformatf("run%0d_tick", k),     32'(out_tick),      32'(vecs[idx].tick));
                check($sformatf("run%0d_val", k),      32'(out_val),       32'(vecs[idx].val));
                check($sformatf("run%0d_level", k),    32'(stat_level),    32'(vecs[idx].level));
                check($sformatf("run%0d_underrun", k), 32'(stat_underrun), 32'(vecs[idx].underrun));
                idx++;
            end
        end
        check("run_tick_count", 32'(nticks), 8);
        check("run_table_done", 32'(idx), 15);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("underrun_cleared", 32'(stat_underrun), 0);

        // Disable mid-run: level 5 with a tick due on the same edge
        push_seq(8'h20, 8);
        nticks = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (out_tick) nticks++;
        end
        check("dis_pre_ticks", 32'(nticks), 3);
        check("dis_pre_level", 32'(stat_level), 5);
        check("dis_pre_val",   32'(out_val), 32'h22);
        cfg_idle = 8'h55;
        cfg_ena  = 1'b0;
        step();
        check("dis_level",    32'(stat_level), 0);
        check("dis_val",      32'(out_val), 32'h55);
        check("dis_tick",     32'(out_tick), 0);
        check("dis_in_ready", 32'(bus.in_ready), 0);
        check("dis_underrun", 32'(stat_underrun), 0);

        // Full back-pressure with 20 offered samples
        cfg_div = 16'd100;
        cfg_ena = 1'b1;
        step();
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_data  = 8'h40 + 8'(accepted);
            bus.in_valid = 1'b1;
            if (c == 15) check("bp_ready_last", 32'(bus.in_ready), 1);
            if (c == 16) begin
                check("bp_ready_full", 32'(bus.in_ready), 0);
                check("bp_level_full", 32'(stat_level), 16);
            end
            if (bus.in_ready) accepted++;
            step();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 16);
        for (int n = 0; n < 16; n++) begin
            wait_tick(200, cyc, ok);
            check($sformatf("bp_tick%0d_seen", n), 32'(ok), 1);
            check($sformatf("bp_pop%0d_val", n), 32'(out_val), 32'h40 + 32'(n));
            if (n == 1) check("bp_tick_spacing", 32'(cyc), 101);
        end
        cyc = 0;
        while (cyc < 120 && !stat_underrun) begin
            step();
            cyc++;
        end
        check("bp_underrun", 32'(stat_underrun), 1);
        check("bp_hold_val", 32'(out_val), 32'h4F);

        // cfg_div = 0: one pop per cycle, back-to-back ticks
        cfg_div = 16'd0;
        push_seq(8'h60, 8);
        step();
        check("div0_entry_tick", 32'(out_tick), 0);
        for (int n = 0; n < 8; n++) begin
            step();
            check($sformatf("div0_tick%0d", n), 32'(out_tick), 1);
            check($sformatf("div0_val%0d", n),  32'(out_val), 32'h60 + 32'(n));
        end
        step();
        check("div0_end_tick", 32'(out_tick), 0);
        check("div0_end_val",  32'(out_val), 32'h67);

        // Asynchronous reset between edges
        push_seq(8'h70, 3);
        check("arst_pre_level",    32'(stat_level), 3);
        check("arst_pre_underrun", 32'(stat_underrun), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_val",  32'(out_val), 0);
        check("arst_out_tick", 32'(out_tick), 0);
        check("arst_in_ready", 32'(bus.in_ready), 0);
        check("arst_level",    32'(stat_level), 0);
        check("arst_underrun", 32'(stat_underrun), 0);
        #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_feed.md
# pdm_feed

Sample feeder for the PDM output stage. It buffers a stream of PCM samples arriving over a valid/ready handshake in a small FIFO. It releases one sample every `cfg_div+1` clock cycles on `out_val`, which drives the PDM core's `cfg_val` directly. It handles pre-buffering (priming), underrun detection and idle-level output, so software or a DMA engine can push audio/LED samples in bursts.

## Interface
- `WIDTH`, 8: sample width; must match the PDM core's `WIDTH`.
- `DEPTH_LOG2`, 4: log2 of FIFO depth (depth 16); must be ≥ 2.
- `DIV_WIDTH`, 16: width of the sample-period divider.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_data`  in  WIDTH  sample to enqueue.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO accepts a sample this cycle.
- `cfg_ena`  in  1  enable playback; 0 flushes the FIFO and forces idle output.
- `cfg_div`  in  DIV_WIDTH  sample period minus 1, in clk cycles.
- `cfg_idle`  in  WIDTH  value driven on `out_val` while disabled.
- `out_val`  out  WIDTH  current sample; connects to PDM `cfg_val`.
- `out_tick`  out  1  one-cycle strobe: `out_val` took a new FIFO sample this cycle.
- `stat_level`  out  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2.
- `stat_underrun`  out  1  sticky flag: a tick found the FIFO empty.
- `stat_clr`  in  1  clears `stat_underrun`.

## Operation
- **States.** There are three states: `IDLE`, `PRIME` and `RUN`.
- **`IDLE`:**
  - `in_ready`=0.
  - FIFO level is forced to 0.
  - `out_val` is registered from `cfg_idle` every cycle.
  - Divider is held at 0.
  - `cfg_ena`=1 moves to `PRIME`.
- **`PRIME`:**
  - `in_ready` = (level < 2^DEPTH_LOG2).
  - `out_val` holds its last value.
  - When level ≥ 2^(DEPTH_LOG2-1), load the divider with `cfg_div` and move to `RUN`.
- **`RUN`:**
  - Divider decrements each cycle.
  - When the divider is 0 (the tick), reload it with `cfg_div`.
  - If the FIFO is non-empty at the tick: pop the head into `out_val` and pulse `out_tick`.
  - If the FIFO is empty at the tick: set `stat_underrun`, hold `out_val`, and go to `PRIME`.
- **Disable.** `cfg_ena`=0 in any state goes to `IDLE` on the next edge. The flush takes priority over any same-cycle push or pop.
- **Push.** A sample is enqueued when `in_valid & in_ready`. `in_ready` depends only on current level and state.
  - At full with a simultaneous pop: no push that cycle.
  - At empty with a simultaneous push at a tick: counts as an underrun (no read-through).
- **Pop and push together.** A push and a pop in the same cycle leave the level unchanged.
- **Divider changes.** Changes to `cfg_div` take effect at the next reload. `cfg_div`=0 means one pop per cycle.
- **Underrun flag.** `stat_clr` clears `stat_underrun`. If an underrun occurs in the same cycle, set wins.
- **Widths.** `stat_level` is an exact count and never wraps. FIFO pointers are DEPTH_LOG2 bits wide and wrap modulo depth.

## Timing
- **Reset values:**
  - State `IDLE`.
  - `out_val`=0; becomes `cfg_idle` on the first edge after reset release.
  - `out_tick`=0, `in_ready`=0, `stat_level`=0, `stat_underrun`=0.
  - Divider=0.
- **Tick to output.** A tick at edge T produces the new `out_val` and `out_tick`=1 visible during cycle T+1. `out_tick` is never high for two consecutive cycles unless `cfg_div`=0.
- **Tick spacing.** The first tick after entering `RUN` occurs `cfg_div+1` cycles after the transition. Later ticks are spaced exactly `cfg_div+1` cycles apart.
- **Push visibility.** A push at edge T is reflected in `stat_level` at T+1.
- **Enable latency.** Deasserting `cfg_ena` gives `out_val`=`cfg_idle` and `stat_level`=0 one cycle later.
- **Mid-operation reset.** An asserted `rst` immediately forces all outputs to their reset values, independent of `clk`.

## Structure
- **Shared package (`pdm_pkg`):**
  - State encoding constants (`ST_IDLE`, `ST_PRIME`, `ST_RUN`).
  - The prime-threshold rule (depth/2).
- **Sub-module `pdm_feed_fifo`:**
  - Synchronous first-word-fall-through FIFO: pointers, level counter, RAM.
  - Flush input.
  - Parameterised by `WIDTH` and `DEPTH_LOG2`.
- **Top level.** `pdm_feed` holds the FSM, divider, output register and status.

## Test plan
- **Reset/idle.**
  - Stimulus: `cfg_idle`=0x80, `cfg_ena`=0, release `rst`.
  - Required: `out_val`=0x00, then 0x80 from the first edge; `in_ready`=0.
- **Prime and run.**
  - Stimulus: `cfg_ena`=1, `cfg_div`=3, push 0x10..0x17 (8 samples).
  - Required: `RUN` entered after the 8th push; `out_tick` every 4 cycles; `out_val` sequence 0x10, 0x11, …, 0x17.
- **Underrun.**
  - Stimulus: continue the previous case with no further pushes.
  - Required: the 9th tick sets `stat_underrun`; `out_val` holds 0x17; FSM returns to `PRIME`; `stat_clr` then clears the flag.
- **Full back-pressure.**
  - Stimulus: `cfg_div`=100, push 20 samples back-to-back.
  - Required: `in_ready` drops once `stat_level`=16; no sample lost or duplicated on the subsequent pops.
- **Disable mid-run.**
  - Stimulus: drop `cfg_ena` with level=5 and a tick due in the same cycle.
  - Required: next cycle `stat_level`=0, `out_val`=`cfg_idle`, `out_tick`=0.
- **Async reset mid-run.**
  - Stimulus: pulse `rst` between clock edges.
  - Required: all outputs at reset values before the next edge.
